// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer
//   Per-scanline sprite engine between the raster timing stage and the sprite
//   bitmap ROM. Each frame it draws exactly HEIGHT rows of NPIX pixels and then
//   idles until the next vstart.
//
//   Optional build macro: SPRITE_MIRROR_EN
//     When defined, each row is drawn and then immediately drawn again
//     horizontally mirrored (NPIX = 2*WIDTH).
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   vstart       one-cycle strobe, raster at the sprite's first line
//   load         one-cycle strobe per line, during horizontal blank
//   hstart       one-cycle strobe, raster at the sprite's first column
//   rom_addr     row address to the bitmap ROM
//   rom_bits     ROM row data, valid one full cycle after rom_addr changes
//   gfx          registered sprite pixel
//   in_progress  high from vstart acceptance until the last row is drawn
module sprite_line_renderer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vstart,
  input  logic              load,
  input  logic              hstart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_bits,
  output logic              gfx,
  output logic              in_progress
);

`ifdef SPRITE_MIRROR_EN
  localparam int NPIX = 2 * WIDTH;
`else
  localparam int NPIX = WIDTH;
`endif
  localparam int PIX_W = $clog2(NPIX + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);
  localparam logic [PIX_W-1:0]  NPIX_C   = PIX_W'(NPIX);

  typedef enum logic [2:0] {
    WAIT_VSTART,
    WAIT_LOAD,
    FETCH_SETUP,
    FETCH,
    WAIT_HSTART,
    DRAW
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row, row_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [WIDTH-1:0]  latch, latch_nxt;
  logic [PIX_W-1:0]  pix, pix_nxt;
  logic              gfx_nxt;
  logic              inp_nxt;

`ifdef SPRITE_MIRROR_EN
  // Second half of the line walks the latch backwards: pixel(i) = latch[2W-1-i].
  function automatic logic pixel_at(input logic [WIDTH-1:0] bits,
                                    input logic [PIX_W-1:0] idx);
    logic [PIX_W-1:0] m;
    if (idx < PIX_W'(WIDTH)) begin
      m = idx;
    end else begin
      m = PIX_W'(2 * WIDTH - 1) - idx;
    end
    return bits[m[IDX_W-1:0]];
  endfunction
`else
  function automatic logic pixel_at(input logic [WIDTH-1:0] bits,
                                    input logic [IDX_W-1:0] idx);
    return bits[idx];
  endfunction
`endif

  logic pix_bit;
`ifdef SPRITE_MIRROR_EN
  assign pix_bit = pixel_at(latch, pix);
`else
  assign pix_bit = pixel_at(latch, pix[IDX_W-1:0]);
`endif

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    addr_nxt  = rom_addr;
    latch_nxt = latch;
    pix_nxt   = pix;
    gfx_nxt   = 1'b0;
    inp_nxt   = in_progress;
    // vstart restarts the frame from any state and beats a coincident hstart.
    if (vstart) begin
      state_nxt = WAIT_LOAD;
      row_nxt   = '0;
      pix_nxt   = '0;
      inp_nxt   = 1'b1;
    end else begin
      case (state)
        WAIT_VSTART: ;
        WAIT_LOAD: begin
          if (load) begin
            addr_nxt  = row;
            state_nxt = FETCH_SETUP;
          end
        end
        FETCH_SETUP: state_nxt = FETCH;
        FETCH: begin
          latch_nxt = rom_bits;
          state_nxt = WAIT_HSTART;
        end
        WAIT_HSTART: begin
          if (hstart) begin
            gfx_nxt   = latch[0];
            pix_nxt   = PIX_W'(1);
            state_nxt = DRAW;
          end
        end
        DRAW: begin
          if (pix < NPIX_C) begin
            gfx_nxt = pix_bit;
            pix_nxt = pix + PIX_W'(1);
          end else begin
            pix_nxt = '0;
            if (row == LAST_ROW) begin
              state_nxt = WAIT_VSTART;
              inp_nxt   = 1'b0;
            end else begin
              row_nxt   = row + ADDR_W'(1);
              state_nxt = WAIT_LOAD;
            end
          end
        end
        default: state_nxt = WAIT_VSTART;
      endcase
    end
  end

  // Register stage: async reset clears gfx at once, mid-draw included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_VSTART;
      row         <= '0;
      rom_addr    <= '0;
      latch       <= '0;
      pix         <= '0;
      gfx         <= 1'b0;
      in_progress <= 1'b0;
    end else begin
      state       <= state_nxt;
      row         <= row_nxt;
      rom_addr    <= addr_nxt;
      latch       <= latch_nxt;
      pix         <= pix_nxt;
      gfx         <= gfx_nxt;
      in_progress <= inp_nxt;
    end
  end

endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 16;
  localparam int ADDR_W = 4;
`ifdef SPRITE_MIRROR_EN
  localparam int NPIX = 2 * WIDTH;
`else
  localparam int NPIX = WIDTH;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              vstart = 1'b0;
  logic              load = 1'b0;
  logic              hstart = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_bits = '0;
  logic              gfx;
  logic              in_progress;

  logic [WIDTH-1:0]  rom [HEIGHT];
  logic              exp_q [$];
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  // ROM with one cycle of read latency.
  always @(posedge clk) rom_bits <= rom[rom_addr];

  sprite_line_renderer #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vstart     (vstart),
    .load       (load),
    .hstart     (hstart),
    .rom_addr   (rom_addr),
    .rom_bits   (rom_bits),
    .gfx        (gfx),
    .in_progress(in_progress)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_vstart();
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  function automatic logic exp_pix(input logic [WIDTH-1:0] b, input int i);
    if (i < WIDTH) return b[i];
    return b[2*WIDTH-1-i];
  endfunction

  // Expected gfx stream: NPIX pixels, then the terminating cycle and one idle cycle.
  task automatic push_line(input logic [WIDTH-1:0] b, input bit draws);
    for (int i = 0; i < NPIX; i++) exp_q.push_back(draws ? exp_pix(b, i) : 1'b0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endtask

  task automatic run_hstart(input string tag);
    logic e;
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {31'd0, gfx}, {31'd0, e});
      if (exp_q.size() > 0) tick();
    end
  endtask

  task automatic draw_row(input int r);
    pulse_load();
    check("line_rom_addr", {28'd0, rom_addr}, r);
    wait_cycles(10);
    check("line_gfx_idle", {31'd0, gfx}, 32'd0);
    push_line(rom[r], 1'b1);
    run_hstart("line_gfx");
  endtask

  initial begin
    for (int r = 0; r < HEIGHT; r++) rom[r] = WIDTH'((r * 29 + 7) ^ 8'hA5);
    rom[0] = 8'b11101110;
    rom[3] = 8'b00000001;

    // Reset hold with strobes toggling.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vstart = 1'($urandom_range(0, 1));
      load   = 1'($urandom_range(0, 1));
      hstart = 1'($urandom_range(0, 1));
      tick();
      check("rst_gfx", {31'd0, gfx}, 32'd0);
      check("rst_in_progress", {31'd0, in_progress}, 32'd0);
      check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    end
    vstart = 1'b0;
    load   = 1'b0;
    hstart = 1'b0;
    reset  = 1'b1;
    tick();
    check("idle_in_progress", {31'd0, in_progress}, 32'd0);

    // Full frame; row 0 is the single-row pattern, row 3 the lone-bit pattern.
    pulse_vstart();
    check("vstart_in_progress", {31'd0, in_progress}, 32'd1);
    for (int r = 0; r < HEIGHT; r++) begin
      draw_row(r);
      check("frame_in_progress", {31'd0, in_progress}, (r == HEIGHT - 1) ? 32'd0 : 32'd1);
    end

    // 17th line after the frame has ended: nothing drawn.
    pulse_load();
    check("post_rom_addr", {28'd0, rom_addr}, HEIGHT - 1);
    wait_cycles(10);
    push_line(rom[0], 1'b0);
    run_hstart("post_gfx");

    // Early hstart lands in FETCH_SETUP and is ignored.
    pulse_vstart();
    pulse_load();
    check("early_rom_addr", {28'd0, rom_addr}, 32'd0);
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("early_gfx", {31'd0, gfx}, 32'd0);
      tick();
    end
    check("early_rom_addr_hold", {28'd0, rom_addr}, 32'd0);
    push_line(rom[0], 1'b1);
    run_hstart("early_redraw");
    for (int r = 1; r < 5; r++) draw_row(r);

    // vstart and hstart together in WAIT_HSTART at row 5.
    pulse_load();
    check("sim_rom_addr", {28'd0, rom_addr}, 32'd5);
    wait_cycles(10);
    vstart = 1'b1;
    hstart = 1'b1;
    tick();
    vstart = 1'b0;
    hstart = 1'b0;
    check("sim_in_progress", {31'd0, in_progress}, 32'd1);
    for (int i = 0; i < NPIX + 1; i++) begin
      check("sim_gfx", {31'd0, gfx}, 32'd0);
      tick();
    end
    pulse_load();
    check("restart_rom_addr", {28'd0, rom_addr}, 32'd0);

    // Asynchronous reset mid-draw clears gfx without waiting for a clock edge.
    wait_cycles(10);
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    check("areset_pix0", {31'd0, gfx}, {31'd0, exp_pix(rom[0], 0)});
    tick();
    check("areset_pix1", {31'd0, gfx}, {31'd0, exp_pix(rom[0], 1)});
    #2;
    reset = 1'b0;
    #1;
    check("areset_gfx", {31'd0, gfx}, 32'd0);
    check("areset_in_progress", {31'd0, in_progress}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    pulse_load();
    wait_cycles(10);
    push_line(rom[0], 1'b0);
    run_hstart("areset_no_resume");
    check("areset_idle", {31'd0, in_progress}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
